// File: rtl/wasm_mem_pkg.sv
// Shared definitions for the wasm load/store unit: opcode values, response
// error codes, sequencer state encoding and the opcode decode helper.
package wasm_mem_pkg;

  localparam logic [7:0] OP_LOAD32   = 8'h28;
  localparam logic [7:0] OP_LOAD8_S  = 8'h2C;
  localparam logic [7:0] OP_LOAD8_U  = 8'h2D;
  localparam logic [7:0] OP_LOAD16_S = 8'h2E;
  localparam logic [7:0] OP_LOAD16_U = 8'h2F;
  localparam logic [7:0] OP_STORE32  = 8'h36;
  localparam logic [7:0] OP_STORE8   = 8'h3A;
  localparam logic [7:0] OP_STORE16  = 8'h3B;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_OOB = 2'd1;
  localparam logic [1:0] ERR_ILL = 2'd2;

  // access sizes in bytes
  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_RESP
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_store;
    logic       is_signed;
    logic [2:0] size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t d;
    d = '0;
    case (op)
      OP_LOAD32:   begin d.legal = 1'b1; d.size = SZ_W; end
      OP_LOAD8_S:  begin d.legal = 1'b1; d.size = SZ_B; d.is_signed = 1'b1; end
      OP_LOAD8_U:  begin d.legal = 1'b1; d.size = SZ_B; end
      OP_LOAD16_S: begin d.legal = 1'b1; d.size = SZ_H; d.is_signed = 1'b1; end
      OP_LOAD16_U: begin d.legal = 1'b1; d.size = SZ_H; end
      OP_STORE32:  begin d.legal = 1'b1; d.size = SZ_W; d.is_store = 1'b1; end
      OP_STORE8:   begin d.legal = 1'b1; d.size = SZ_B; d.is_store = 1'b1; end
      OP_STORE16:  begin d.legal = 1'b1; d.size = SZ_H; d.is_store = 1'b1; end
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wasm_mem_align.sv
// Byte-lane alignment, purely combinational.
//   size/sh/is_signed : access size in bytes, byte offset in word, sign-extend
//   st_val            : store value (low size bytes used)
//   st_data/st_mask   : two-word lane image of the store and its bit mask
//   rd0/rd1           : first and second read words (rd1 = 0 when no span)
//   ld_val            : extracted and extended load result
module wasm_mem_align
  import wasm_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  sh,
  input  logic        is_signed,
  input  logic [31:0] st_val,
  output logic [63:0] st_data,
  output logic [63:0] st_mask,
  input  logic [31:0] rd0,
  input  logic [31:0] rd1,
  output logic [31:0] ld_val
);

  logic [31:0] lane_val;
  logic [31:0] lane_mask;
  logic [31:0] raw;

  always_comb begin
    lane_val  = st_val;
    lane_mask = 32'hFFFF_FFFF;
    // bring the addressed byte down to lane 0 of the two-word window
    raw       = 32'({rd1, rd0} >> {sh, 3'b000});
    ld_val    = raw;
    case (size)
      SZ_B: begin
        lane_val  = {24'h0, st_val[7:0]};
        lane_mask = 32'h0000_00FF;
        ld_val    = {{24{is_signed & raw[7]}}, raw[7:0]};
      end
      SZ_H: begin
        lane_val  = {16'h0, st_val[15:0]};
        lane_mask = 32'h0000_FFFF;
        ld_val    = {{16{is_signed & raw[15]}}, raw[15:0]};
      end
      default: ;
    endcase
    st_data = {32'h0, lane_val}  << {sh, 3'b000};
    st_mask = {32'h0, lane_mask} << {sh, 3'b000};
  end

endmodule

// File: rtl/wasm_mem_unit.sv
// Load/store sequencer between the wasm core and a word-addressed memory.
//   req_*        : request (opcode, base, offset, store value), valid/ready
//   resp_*       : extended load data and error code, valid/ready
//   mem_cmd_*    : word-aligned read / masked-write command, start/ready
//   mem_rdata*   : read data and command-complete flag
// Unaligned accesses that cross a word are split into two commands.
module wasm_mem_unit
  import wasm_mem_pkg::*;
#(
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_ready
);

  localparam logic [33:0] MEM_BYTES = 34'(4 * MEM_WORDS);

  state_t      state;
  logic [7:0]  op_q;
  logic [31:0] base_q, off_q, wdata_q, r0_q;

  op_info_t    info;
  logic [32:0] ea;
  logic [33:0] ea_end;
  logic [31:0] wa;
  logic        span;
  logic [63:0] st_data, st_mask;
  logic [31:0] rd0, rd1, ld_val, resp_val;

  // Latched request fields stay stable for the whole transaction, so the
  // address arithmetic is recomputed combinationally instead of registered.
  assign info   = decode_op(op_q);
  assign ea     = {1'b0, base_q} + {1'b0, off_q};
  assign ea_end = {1'b0, ea} + {31'h0, info.size};
  assign wa     = {ea[31:2], 2'b00};
  assign span   = ({1'b0, ea[1:0]} + info.size) > 3'd4;

  // The final read word is used straight off the bus so the response can be
  // registered on the same edge that captures it.
  assign rd0      = (state == S_WAIT0) ? mem_rdata : r0_q;
  assign rd1      = (state == S_WAIT1) ? mem_rdata : 32'h0;
  assign resp_val = info.is_store ? 32'h0 : ld_val;

  assign req_ready = (state == S_IDLE) && !rst;

  wasm_mem_align u_align (
    .size      (info.size),
    .sh        (ea[1:0]),
    .is_signed (info.is_signed),
    .st_val    (wdata_q),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .rd0       (rd0),
    .rd1       (rd1),
    .ld_val    (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      resp_valid    <= 1'b0;
      resp_data     <= 32'h0;
      resp_err      <= ERR_OK;
      mem_cmd_start <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op_q    <= req_opcode;
          base_q  <= req_base;
          off_q   <= req_offset;
          wdata_q <= req_wdata;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (!info.legal) begin
            resp_valid <= 1'b1;
            resp_err   <= ERR_ILL;
            resp_data  <= 32'h0;
            state      <= S_RESP;
          end else if (ea_end > MEM_BYTES) begin
            // 34-bit compare also catches base+offset wrapping past 2^32
            resp_valid <= 1'b1;
            resp_err   <= ERR_OOB;
            resp_data  <= 32'h0;
            state      <= S_RESP;
          end else begin
            mem_cmd_start <= 1'b1;
            mem_cmd_write <= info.is_store;
            mem_addr      <= wa;
            mem_wdata     <= info.is_store ? st_data[31:0] : 32'h0;
            mem_wmask     <= info.is_store ? st_mask[31:0] : 32'h0;
            state         <= S_ISSUE0;
          end
        end
        S_ISSUE0: if (mem_cmd_ready) begin
          mem_cmd_start <= 1'b0;
          state         <= S_WAIT0;
        end
        S_WAIT0: if (mem_rdata_ready) begin
          r0_q <= mem_rdata;
          if (span) begin
            mem_cmd_start <= 1'b1;
            mem_addr      <= wa + 32'd4;
            mem_wdata     <= info.is_store ? st_data[63:32] : 32'h0;
            mem_wmask     <= info.is_store ? st_mask[63:32] : 32'h0;
            state         <= S_ISSUE1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_data  <= resp_val;
            state      <= S_RESP;
          end
        end
        S_ISSUE1: if (mem_cmd_ready) begin
          mem_cmd_start <= 1'b0;
          state         <= S_WAIT1;
        end
        S_WAIT1: if (mem_rdata_ready) begin
          resp_valid <= 1'b1;
          resp_err   <= ERR_OK;
          resp_data  <= resp_val;
          state      <= S_RESP;
        end
        S_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_data  <= 32'h0;
          resp_err   <= ERR_OK;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_mem_unit.sv
// Self-checking bench for wasm_mem_unit: table of requests with expected
// memory commands and responses, a one-cycle-busy memory model, scoreboards
// for commands and responses, plus stall / backpressure / reset sequences.
module tb_wasm_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [7:0]  req_opcode = '0;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready;
  logic [31:0] mem_addr, mem_wdata, mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_ready;

  always #5 clk = ~clk;

  wasm_mem_unit #(.MEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready)
  );

  int errors = 0, checks = 0, cyc = 0, nstart = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory: busy for one cycle after accepting, then flags completion
  logic [31:0] mem [0:2047] = '{default: 32'h0};
  logic        busy = 1'b0, rdq = 1'b0, stall = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, p_mask = '0;
  assign mem_cmd_ready   = !busy && !stall;
  assign mem_rdata_ready = rdq;

  always @(posedge clk) begin
    if (busy) begin
      busy <= 1'b0;
      rdq  <= 1'b1;
      if (p_wr) mem[p_addr[12:2]] <= (mem[p_addr[12:2]] & ~p_mask) | (p_wdata & p_mask);
      else      mem_rdata <= mem[p_addr[12:2]];
    end else if (mem_cmd_start && mem_cmd_ready) begin
      busy <= 1'b1; rdq <= 1'b0;
      p_wr <= mem_cmd_write; p_addr <= mem_addr; p_wdata <= mem_wdata; p_mask <= mem_wmask;
    end
  end

  typedef struct { logic wr; logic [31:0] addr, wdata, mask; } cmd_t;
  typedef struct { logic [31:0] data; logic [1:0] err; int lat; int acc; } rsp_t;
  typedef struct {
    logic [7:0] op; logic [31:0] base, off, wdata, exp_data; logic [1:0] exp_err;
    int lat; int ncmd; logic wr; logic [31:0] a0, d0, m0, a1, d1, m1;
  } vec_t;

  cmd_t cmdq[$];
  rsp_t rspq[$];

  // command scoreboard
  always @(negedge clk) begin
    if (mem_cmd_start) nstart++;
    if (mem_cmd_start && mem_cmd_ready) begin
      if (cmdq.size() == 0) chk("cmd_unexpected", mem_addr, 32'hFFFF_FFFF);
      else begin
        cmd_t c;
        c = cmdq.pop_front();
        chk("cmd_write", {31'h0, mem_cmd_write}, {31'h0, c.wr});
        chk("cmd_addr", mem_addr, c.addr);
        if (c.wr) begin
          chk("cmd_wdata", mem_wdata, c.wdata);
          chk("cmd_wmask", mem_wmask, c.mask);
        end
      end
    end
  end

  // response scoreboard
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (rspq.size() == 0) chk("resp_unexpected", resp_data, 32'hFFFF_FFFF);
      else begin
        rsp_t r;
        r = rspq.pop_front();
        chk("resp_data", resp_data, r.data);
        chk("resp_err", {30'h0, resp_err}, {30'h0, r.err});
        if (r.lat != 0) chk("latency", cyc - r.acc + 1, r.lat);
      end
    end
  end

  task automatic send(input vec_t v, input bit want_resp);
    int n = 0;
    rsp_t r;
    cmd_t c;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("req_ready_timeout", 32'h0, 32'h1); return; end
    req_valid = 1'b1; req_opcode = v.op; req_base = v.base;
    req_offset = v.off; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (want_resp) begin
      r.data = v.exp_data; r.err = v.exp_err; r.lat = v.lat; r.acc = cyc;
      rspq.push_back(r);
    end
    if (v.ncmd >= 1) begin
      c.wr = v.wr; c.addr = v.a0; c.wdata = v.d0; c.mask = v.m0; cmdq.push_back(c);
    end
    if (v.ncmd >= 2) begin
      c.wr = v.wr; c.addr = v.a1; c.wdata = v.d1; c.mask = v.m1; cmdq.push_back(c);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rspq.size() != 0 || !req_ready) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      chk("resp_timeout", rspq.size(), 32'h0);
      rspq.delete();
    end
  endtask

  vec_t v[21];
  vec_t vs;
  int   s0, n;

  initial begin
    // op, base, off, wdata, exp_data, exp_err, lat, ncmd, wr, a0, d0, m0, a1, d1, m1
    v[0]  = '{8'h36, 32'h10, 32'h0, 32'h11223344, 32'h0, 2'd0, 0, 1, 1'b1, 32'h10, 32'h11223344, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    v[1]  = '{8'h28, 32'h10, 32'h0, 32'h0, 32'h11223344, 2'd0, 5, 1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[2]  = '{8'h3A, 32'h10, 32'h3, 32'hAB, 32'h0, 2'd0, 0, 1, 1'b1, 32'h10, 32'hAB000000, 32'hFF000000, 32'h0, 32'h0, 32'h0};
    v[3]  = '{8'h2C, 32'h13, 32'h0, 32'h0, 32'hFFFFFFAB, 2'd0, 0, 1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[4]  = '{8'h2D, 32'h10, 32'h3, 32'h0, 32'h000000AB, 2'd0, 0, 1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[5]  = '{8'h3B, 32'h1F, 32'h0, 32'h1234BEEF, 32'h0, 2'd0, 0, 2, 1'b1, 32'h1C, 32'hEF000000, 32'hFF000000, 32'h20, 32'h000000BE, 32'h000000FF};
    v[6]  = '{8'h2E, 32'h1F, 32'h0, 32'h0, 32'hFFFFBEEF, 2'd0, 0, 2, 1'b0, 32'h1C, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0};
    v[7]  = '{8'h2F, 32'h1E, 32'h1, 32'h0, 32'h0000BEEF, 2'd0, 0, 2, 1'b0, 32'h1C, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0};
    v[8]  = '{8'h28, 32'h1E, 32'h0, 32'h0, 32'h00BEEF00, 2'd0, 0, 2, 1'b0, 32'h1C, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0};
    v[9]  = '{8'h36, 32'h1FFC, 32'h0, 32'hCAFEF00D, 32'h0, 2'd0, 0, 1, 1'b1, 32'h1FFC, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    v[10] = '{8'h28, 32'h1FFC, 32'h0, 32'h0, 32'hCAFEF00D, 2'd0, 5, 1, 1'b0, 32'h1FFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[11] = '{8'h28, 32'h1FFE, 32'h0, 32'h0, 32'h0, 2'd1, 2, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[12] = '{8'h28, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 2'd1, 2, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[13] = '{8'h29, 32'h10, 32'h0, 32'h0, 32'h0, 2'd2, 2, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[14] = '{8'h3A, 32'h1FF0, 32'hF, 32'h5A, 32'h0, 2'd0, 0, 1, 1'b1, 32'h1FFC, 32'h5A000000, 32'hFF000000, 32'h0, 32'h0, 32'h0};
    v[15] = '{8'h2C, 32'h1FFC, 32'h0, 32'h0, 32'h0000000D, 2'd0, 0, 1, 1'b0, 32'h1FFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[16] = '{8'h28, 32'h1FFC, 32'h0, 32'h0, 32'h5AFEF00D, 2'd0, 0, 1, 1'b0, 32'h1FFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[17] = '{8'h2F, 32'h1FFF, 32'h0, 32'h0, 32'h0, 2'd1, 2, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[18] = '{8'h3B, 32'h1FFE, 32'h0, 32'h7777, 32'h0, 2'd0, 0, 1, 1'b1, 32'h1FFC, 32'h77770000, 32'hFFFF0000, 32'h0, 32'h0, 32'h0};
    v[19] = '{8'h2E, 32'h1FFE, 32'h0, 32'h0, 32'h00007777, 2'd0, 0, 1, 1'b0, 32'h1FFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[20] = '{8'h28, 32'h10, 32'hFFFFFFF0, 32'h0, 32'h0, 2'd1, 2, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_cmd_start", {31'h0, mem_cmd_start}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 21; i++) begin
      s0 = nstart;
      send(v[i], 1'b1);
      wait_done();
      if (v[i].exp_err != 2'd0) chk("no_cmd_on_err", nstart - s0, 32'h0);
    end

    // memory stalls the first command: start and address must hold
    vs = v[1]; vs.exp_data = 32'hAB223344; vs.lat = 0;
    @(posedge clk); #1 stall = 1'b1;
    send(vs, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("stall_start", {31'h0, mem_cmd_start}, 32'h1);
      chk("stall_addr", mem_addr, 32'h10);
      @(negedge clk);
    end
    @(posedge clk); #1 stall = 1'b0;
    wait_done();

    // consumer backpressure: response held, no new request accepted
    @(posedge clk); #1 resp_ready = 1'b0;
    send(vs, 1'b1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_data", resp_data, 32'hAB223344);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_done();

    // reset while waiting for the first read word
    send(vs, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wait0_start_low", {31'h0, mem_cmd_start}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_resp_data", resp_data, 32'h0);
    chk("mid_rst_resp_err", {30'h0, resp_err}, 32'h0);
    chk("mid_rst_cmd_start", {31'h0, mem_cmd_start}, 32'h0);
    chk("mid_rst_cmd_write", {31'h0, mem_cmd_write}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wmask", mem_wmask, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    vs.lat = 5;
    send(vs, 1'b1);
    wait_done();

    repeat (4) @(negedge clk);
    chk("cmdq_empty", cmdq.size(), 32'h0);
    chk("rspq_empty", rspq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wasm_mem_unit.md
Name: wasm_mem_unit

Overview:
Load/store sequencer between the wasm execution core and the word memory. It takes a wasm i32 memory opcode with base, immediate offset and store value, and computes and bounds-checks the effective address. It then issues only word-aligned read or masked-write commands over the memory's start/ready/rdata_ready handshake, splitting accesses that straddle a word boundary into two commands. Load results are merged, sign- or zero-extended, and returned on a valid/ready response port.

Parameters:
MEM_WORDS, 2048, number of 32-bit words in the downstream memory; MEM_BYTES = 4*MEM_WORDS

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle and accepting requests
req_opcode  in  8  wasm opcode
req_base  in  32  dynamic address operand
req_offset  in  32  memarg offset
req_wdata  in  32  store value (low bytes used for store8/16)
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_data  out  32  extended load value; 0 for stores and errors
resp_err  out  2  0 ok, 1 out-of-bounds trap, 2 illegal opcode
mem_cmd_start  out  1  command request
mem_cmd_write  out  1  1 = write
mem_cmd_ready  in  1  memory idle
mem_addr  out  32  byte address, always a multiple of 4
mem_wdata  out  32  byte k of the word at bits [8k+7:8k]
mem_wmask  out  32  per-bit write mask, same lane layout
mem_rdata  in  32  read word, same lane layout
mem_rdata_ready  in  1  command complete; cleared by memory on acceptance

Behaviour:
- Reset (synchronous, active-high, takes priority in any state): state IDLE. All outputs are 0 except req_ready. req_ready stays 0 while rst is high.
- Supported opcodes and access sizes n:
  - 0x28 load32 (n=4); 0x2C load8_s, 0x2D load8_u (n=1); 0x2E load16_s, 0x2F load16_u (n=2).
  - 0x36 store32 (n=4); 0x3A store8 (n=1); 0x3B store16 (n=2).
  - Any other opcode -> resp_err=2.
- States: IDLE, CHECK, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields and go to CHECK.
- CHECK: compute 33-bit ea = base + offset.
  - Illegal opcode -> RESP with err 2.
  - ea + n > MEM_BYTES, evaluated at 34 bits so offset overflow also traps -> RESP with err 1. No memory command is issued on any error.
  - Otherwise: sh = ea[1:0], wa = {ea[31:2],2'b00}, span = (sh + n > 4). Go to ISSUE0.
- Store lanes:
  - D64 = zero-extended size-n value << 8*sh; M64 = n-byte ones mask << 8*sh.
  - Word0: addr wa, wdata D64[31:0], wmask M64[31:0].
  - Word1 (only when span): addr wa+4, wdata D64[63:32], wmask M64[63:32].
- ISSUEx: drive mem_cmd_start=1 with mem_addr, mem_wdata, mem_wmask and mem_cmd_write held stable. Handshake is start && mem_cmd_ready at a rising edge, then go to WAITx. mem_rdata_ready is not sampled while in ISSUEx.
- WAITx: mem_cmd_start=0. When mem_rdata_ready=1, capture mem_rdata as R0 or R1.
  - After WAIT0: go to ISSUE1 if span, else RESP.
  - After WAIT1: go to RESP.
- Load result: ({R1,R0} >> 8*sh) truncated to n bytes, then sign- or zero-extended to 32 bits. R1 counts as 0 when there is no span.
- RESP: resp_valid=1 with data and err held until resp_ready. Handshake returns to IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Latency: aligned non-spanning load with idle memory -> resp_valid high in the 5th cycle after the acceptance edge. Error responses -> 2nd cycle.
- Reset mid-transaction: abandon the access and return to IDLE. The next request still waits for mem_cmd_ready, so a command left in flight in the memory is tolerated.

Decomposition:
- Package wasm_mem_pkg: opcode localparams, resp_err codes, state encoding, and an opcode -> {size, is_store, is_signed, legal} decode function.
- Sub-module wasm_mem_align, purely combinational: produces D64/M64 for stores and performs the load extract/extend. The sequencer FSM stays in wasm_mem_unit.

Test Plan:
- store32 ea 0x10 data 0x11223344 -> one write: addr 0x10, mask 0xFFFFFFFF. Then load32 at 0x10 -> resp_data 0x11223344, err 0, resp_valid exactly 5 cycles after acceptance.
- store8 base 0x10 offset 3, data 0x000000AB -> one write: addr 0x10, wdata 0xAB000000, wmask 0xFF000000. Then load8_s at 0x13 -> 0xFFFFFFAB; load8_u -> 0x000000AB.
- store16 ea 0x1F data 0xBEEF -> two writes: (0x1C, 0xEF000000, 0xFF000000) then (0x20, 0x000000BE, 0x000000FF). Then load16_s at 0x1F -> 0xFFFFBEEF via two reads; load16_u -> 0x0000BEEF.
- Bounds: load32 ea 0x1FFC -> ok. load32 ea 0x1FFE -> err 1. base 0xFFFFFFFF offset 1 -> err 1. The two error cases raise no mem_cmd_start.
- Opcode 0x29 -> err 2, resp_data 0. Holding mem_cmd_ready=0 for 10 cycles keeps the unit in ISSUE0 with start asserted and address stable.
- Hold resp_ready=0 for 5 cycles -> response held, req_ready=0. Assert rst during WAIT0 -> next cycle IDLE with all outputs 0. A subsequent load32 completes correctly.
